// File: rtl/timersoc_gpio_in.sv
// timersoc_gpio_in: Avalon-MM input port with 2-flop sync, edge capture and maskable level irq.
// Capture is held off for the first three clocks after reset so levels present at release never register as edges.
module timersoc_gpio_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2, prev, mask, cap, edges, clr;
    logic [1:0]       arm;
    logic             armed, wr;
    logic [31:0]      rd_mux;
    logic             unused_ok;

    always_comb begin
        wr        = chipselect & ~write_n;
        armed     = arm == 2'd3;
        edges     = EDGE_TYPE == 0 ? s2 & ~prev : EDGE_TYPE == 1 ? ~s2 & prev : s2 ^ prev;
        clr       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        rd_mux    = address == 2'd0 ? 32'(s2) : address == 2'd2 ? 32'(mask) :
                    address == 2'd3 ? 32'(cap) : 32'd0;
        irq       = |(cap & mask);
        unused_ok = &{1'b0, writedata};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            mask     <= '0;
            cap      <= '0;
            arm      <= '0;
            readdata <= '0;
        end else begin
            s1       <= in_port;
            s2       <= s1;
            prev     <= s2;
            arm      <= armed ? arm : arm + 2'd1;
            if (wr && address == 2'd2) mask <= writedata[WIDTH-1:0];
            // a new edge wins over a simultaneous write-1-to-clear
            cap      <= (armed ? edges : '0) | (cap & ~clr);
            readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_timersoc_gpio_in.sv
// tb_timersoc_gpio_in: three edge-type builds driven together, checked against an input-history model.
// Directed vectors add literal expectations for the rising build and the edge-type differences.
module tb_timersoc_gpio_in;
    logic             clk = 0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect, write_n;
    logic [31:0]      writedata;
    logic [7:0]       in_port;
    logic [2:0][31:0] rd;
    logic [2:0]       irqv;
    int               checks = 0, failures = 0;

    always #5 clk = ~clk;

    timersoc_gpio_in #(.WIDTH(8), .EDGE_TYPE(0)) d0 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irqv[0]));
    timersoc_gpio_in #(.WIDTH(8), .EDGE_TYPE(1)) d1 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irqv[1]));
    timersoc_gpio_in #(.WIDTH(8), .EDGE_TYPE(2)) d2 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irqv[2]));

    // model: h1/h2/h3 are the input values seen one, two and three clocks ago
    logic [7:0]       h1, h2, h3, m_mask;
    logic [2:0][7:0]  m_cap;
    logic [2:0][31:0] m_rd;
    int               n;

    function automatic logic [7:0] edg(int t, logic [7:0] cur, logic [7:0] old);
        return t == 0 ? cur & ~old : t == 1 ? ~cur & old : cur ^ old;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h1 <= 0; h2 <= 0; h3 <= 0; n <= 0; m_mask <= 0; m_cap <= '0; m_rd <= '0;
        end else begin
            h1 <= in_port; h2 <= h1; h3 <= h2;
            if (n < 3) n <= n + 1;
            if (chipselect && !write_n && address == 2) m_mask <= writedata[7:0];
            for (int t = 0; t < 3; t++) begin
                m_cap[t] <= (n >= 3 ? edg(t, h2, h3) : 8'h00) |
                            (m_cap[t] & ~((chipselect && !write_n && address == 3) ? writedata[7:0] : 8'h00));
                m_rd[t]  <= address == 0 ? {24'h0, h2} : address == 2 ? {24'h0, m_mask} :
                            address == 3 ? {24'h0, m_cap[t]} : 32'h0;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("model rd%0d", t), rd[t], m_rd[t]);
            chk($sformatf("model irq%0d", t), {31'b0, irqv[t]}, {31'b0, |(m_cap[t] & m_mask)});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        tick();
        chipselect = 0; write_n = 1;
    endtask

    initial begin
        reset_n = 0; in_port = 8'hFF; address = 0; chipselect = 0; write_n = 1; writedata = 0;
        repeat (2) tick();
        chk("reset rd", rd[0], 32'h0);
        chk("reset irq", {31'b0, irqv[0]}, 32'h0);
        reset_n = 1;
        repeat (3) tick();
        chk("data FF by edge 3", rd[0], 32'hFF);
        address = 3;
        repeat (5) tick();
        chk("no capture at release", rd[0], 32'h0);
        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h05;
        repeat (3) tick();
        chk("cap not before k+2", rd[0], 32'h0);
        tick();
        chk("cap 05", rd[0], 32'h05);
        chk("irq masked", {31'b0, irqv[0]}, 32'h0);
        wr(2, 32'h04);
        chk("irq after mask", {31'b0, irqv[0]}, 32'h1);
        wr(3, 32'h01);
        chk("irq stays", {31'b0, irqv[0]}, 32'h1);
        address = 3; tick();
        chk("cap 04", rd[0], 32'h04);
        wr(3, 32'h04);
        chk("irq cleared", {31'b0, irqv[0]}, 32'h0);
        address = 3; tick();
        chk("cap 0", rd[0], 32'h0);
        in_port = 8'h04;
        repeat (4) tick();
        in_port = 8'h05;
        repeat (2) tick();
        wr(3, 32'h01);
        address = 3; tick();
        chk("set wins", rd[0], 32'h01);
        wr(3, 32'hFF);
        in_port = 8'h0D;
        address = 3; repeat (5) tick();
        chk("rise rising", rd[0], 32'h08);
        chk("rise falling", rd[1], 32'h00);
        chk("rise any", rd[2], 32'h08);
        wr(3, 32'hFF);
        in_port = 8'h05;
        address = 3; repeat (5) tick();
        chk("fall rising", rd[0], 32'h00);
        chk("fall falling", rd[1], 32'h08);
        chk("fall any", rd[2], 32'h08);
        wr(2, 32'h08);
        chk("irq falling", {31'b0, irqv[1]}, 32'h1);
        address = 2; tick();
        chk("mask read", rd[1], 32'h08);
        #2 reset_n = 0;
        #1;
        chk("async irq", {29'b0, irqv}, 32'h0);
        chk("async rd0", rd[0], 32'h0);
        chk("async rd1", rd[1], 32'h0);
        tick();
        reset_n = 1; address = 3;
        tick();
        in_port = 8'h0D;
        repeat (4) tick();
        chk("rearm rising", rd[0], 32'h08);
        chk("rearm falling", rd[1], 32'h00);
        chk("rearm any", rd[2], 32'h08);
        address = 2; tick();
        chk("mask reset", rd[0], 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timersoc_gpio_in.md
# timersoc_gpio_in

Avalon-MM slave input port that samples an 8-bit external input bus, synchronizes it into the clock domain, detects edges, latches them in sticky capture bits and raises a maskable level interrupt. It is the input-direction counterpart to the SoC's output GPIO register. It hangs off the same Avalon-MM interconnect, with a fixed read latency of 1.

## Interface
- WIDTH, 8, number of input bits (1..32)
- EDGE_TYPE, 0, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits [WIDTH-1:0] used
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data; upper bits always 0
- irq  out  1  level interrupt, high while any unmasked capture bit is set

## Operation
Register map:
- 0 DATA: read returns the synchronized input (sync stage 2). Writes are ignored.
- 1: reads 0; writes ignored.
- 2 IRQ_MASK: read/write; reset 0.
- 3 EDGE_CAP: read returns capture bits. Write-1-to-clear per bit; write 0 leaves a bit unchanged.

Input path:
- The synchronizer is 2 flops, s1 then s2.
- prev register holds the previous s2.
- edge[i] is decided per EDGE_TYPE:
  - rising: s2 & ~prev
  - falling: ~s2 & prev
  - any: s2 ^ prev

Arming:
- A 2-bit arm counter starts at 0 on reset and increments each clock until it reaches 3, then saturates.
- Edge detection is gated off while the counter is below 3. A level already present at reset release therefore never causes a capture.

Capture update each clock, per bit:
- If an edge is detected and detection is armed, the bit is set.
- Otherwise, if there is a write to address 3 with writedata[i]=1, the bit is cleared.
- Otherwise the bit holds.
- Set wins over a simultaneous clear.

Other behaviour:
- irq = |(EDGE_CAP & IRQ_MASK). It is combinational from registers and has no extra flop.
- A write to address 2 loads IRQ_MASK from writedata[WIDTH-1:0].
- readdata is loaded every clock with the mux output for the current address. Bus read strobes are not needed and reads have no side effects.

Reset values:
- s1, s2, prev, IRQ_MASK, EDGE_CAP, arm counter and readdata are all 0, so irq is 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). Arming restarts from the beginning.

## Timing
- in_port changes before edge k:
  - s1 updates at edge k.
  - s2 updates at k+1.
  - The edge is detected combinationally between k+1 and k+2.
  - EDGE_CAP sets at k+2, and irq rises after k+2.
  - DATA readback appears on readdata after edge k+2, provided address is 0 at edge k+2.
- Read: with address presented at edge n, readdata is valid after edge n (read latency 1).
- Write to IRQ_MASK at edge n: irq reflects the new mask after edge n.
- Write-1-to-clear at edge n: the capture bit and irq fall after edge n, unless a same-cycle edge re-sets the bit.
- Pulses shorter than one clock period may be missed. A pulse of 2 or more periods is always captured.
- Arming: edges that would capture at edge 1, 2 or 3 after reset release are discarded. Capture is possible from edge 4 onward.

## Test plan
- Reset, then hold in_port=8'hFF before and after release. Required: EDGE_CAP stays 0, irq stays 0, and DATA reads 8'hFF by edge 3.
- After arming, drive in_port 8'h00 to 8'h05 (rising, default EDGE_TYPE). Required: EDGE_CAP=8'h05 exactly 2 edges later. irq stays 0 with mask 0. Writing mask 8'h04 makes irq=1 after that write edge.
- Write 8'h01 to address 3. Required: EDGE_CAP=8'h04 and irq stays 1. Then write 8'h04: EDGE_CAP=0 and irq=0.
- Same-cycle collision: time a write of 8'h01 to address 3 so it lands on the same edge as a new rising edge on bit 0. Required: bit 0 remains 1.
- EDGE_TYPE=1 and EDGE_TYPE=2 builds: toggle bit 3 as 0→1→0. Required: falling captures only on the 1→0 transition, and any captures on both (clear between transitions).
- Assert reset_n low mid-operation with irq=1. Required: irq, EDGE_CAP, IRQ_MASK and readdata all go 0 immediately, and re-arming takes 3 edges again.
